sound_scheduler: RTL and testbench

- Arbitrates one-cycle sound-effect requests from game logic (menu, level-advance, crash, win events) onto a single square-wave tone generator.
- Latches pending requests and picks one by fixed priority. A strictly higher-priority sound preempts the one playing.
- Steps the chosen sound through its multi-note sequence from a small ROM, driving half-period and enable to the tone generator.

---
 rtl/frogger_pkg.sv | 37 +++
 rtl/sound_rom.sv | 27 ++
 rtl/sound_scheduler.sv | 147 ++++++++++++++
 tb/tb_sound_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - sound ids, note record, scheduler states and sound priority helper
package frogger_pkg;

    typedef enum logic [1:0] {
        UI_PRESS    = 2'd0,
        NEXTLEVEL   = 2'd1,
        CRASH       = 2'd2,
        CELEBRATION = 2'd3
    } sound_t;

    typedef struct packed {
        logic [15:0] half_period;
        logic [3:0]  dur;
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    localparam int MAX_NOTES = 4;

    // Larger value wins arbitration and may preempt a smaller one.
    function automatic logic [1:0] prio(input sound_t s);
        logic [1:0] p;
        case (s)
            CRASH:       p = 2'd3;
            CELEBRATION: p = 2'd2;
            NEXTLEVEL:   p = 2'd1;
            default:     p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sound_rom.sv
// rtl/sound_rom.sv - combinational note table, unused slots have dur=0
module sound_rom
    import frogger_pkg::*;
(
    input  sound_t     sound,
    input  logic [1:0] idx,
    output note_t      note
);

    always_comb begin
        note = '0;
        case ({sound, idx})
            {UI_PRESS,    2'd0}: note = '{half_period: 16'd1000, dur: 4'd1};
            {NEXTLEVEL,   2'd0}: note = '{half_period: 16'd800,  dur: 4'd2};
            {NEXTLEVEL,   2'd1}: note = '{half_period: 16'd600,  dur: 4'd2};
            {NEXTLEVEL,   2'd2}: note = '{half_period: 16'd400,  dur: 4'd4};
            {CRASH,       2'd0}: note = '{half_period: 16'd3000, dur: 4'd4};
            {CRASH,       2'd1}: note = '{half_period: 16'd4000, dur: 4'd8};
            {CELEBRATION, 2'd0}: note = '{half_period: 16'd500,  dur: 4'd2};
            {CELEBRATION, 2'd1}: note = '{half_period: 16'd400,  dur: 4'd2};
            {CELEBRATION, 2'd2}: note = '{half_period: 16'd300,  dur: 4'd2};
            {CELEBRATION, 2'd3}: note = '{half_period: 16'd250,  dur: 4'd8};
            default:             note = '0;
        endcase
    end

endmodule

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - priority sound-effect sequencer for one tone generator; SOUND_SCHED_MUTE_EN adds a mute input
module sound_scheduler
    import frogger_pkg::*;
#(
    parameter int NOTE_TICKS = 25000,
    parameter int GAP_TICKS  = 2500
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SOUND_SCHED_MUTE_EN
    input  logic        mute,
`endif
    input  logic [3:0]  req,
    output logic [15:0] tone_half_period,
    output logic        tone_en,
    output logic        busy,
    output logic [1:0]  cur_sound,
    output logic        done
);

    localparam int CNT_MAX = (15 * NOTE_TICKS > GAP_TICKS) ? 15 * NOTE_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    sched_state_t state, state_n;
    sound_t       snd_q, snd_n, cand;
    logic [1:0]   note_idx, idx_n, rom_idx;
    cnt_t         cnt, cnt_n;
    logic [15:0]  hp_q, hp_n;
    logic [3:0]   pending, pend_n, req_eff, cand_vec, cur_mask;
    logic         done_q, done_n, preempt, last_note;
    note_t        rom_note;

    // In PLAY the ROM looks one note ahead to detect the end of the sequence.
    assign rom_idx = (state == PLAY) ? note_idx + 2'd1 : note_idx;

    sound_rom u_rom (
        .sound (snd_q),
        .idx   (rom_idx),
        .note  (rom_note)
    );

    assign busy      = (state != IDLE);
    assign cur_mask  = busy ? (4'b0001 << snd_q) : 4'b0000;
    assign req_eff   = req & ~cur_mask;
    assign cand_vec  = pending | req_eff;
    assign last_note = (note_idx == 2'(MAX_NOTES - 1)) || (rom_note.dur == 4'd0);

    always_comb begin
        cand = UI_PRESS;
        if (cand_vec[CRASH])
            cand = CRASH;
        else if (cand_vec[CELEBRATION])
            cand = CELEBRATION;
        else if (cand_vec[NEXTLEVEL])
            cand = NEXTLEVEL;
    end

    assign preempt = busy && (|cand_vec) && (prio(cand) > prio(snd_q));

    always_comb begin
        state_n = state;
        snd_n   = snd_q;
        idx_n   = note_idx;
        cnt_n   = cnt;
        hp_n    = hp_q;
        pend_n  = cand_vec;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (|cand_vec) begin
                    state_n = LOAD;
                    snd_n   = cand;
                    idx_n   = 2'd0;
                    pend_n  = cand_vec & ~(4'b0001 << cand);
                end
            end
            LOAD: begin
                state_n = PLAY;
                hp_n    = rom_note.half_period;
                cnt_n   = cnt_t'(rom_note.dur) * cnt_t'(NOTE_TICKS) - cnt_t'(1);
            end
            PLAY: begin
                if (cnt == '0) begin
                    if (last_note) begin
                        state_n = IDLE;
                        snd_n   = UI_PRESS;
                        idx_n   = 2'd0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = GAP;
                        cnt_n   = cnt_t'(GAP_TICKS - 1);
                    end
                end else begin
                    cnt_n = cnt - cnt_t'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = LOAD;
                    idx_n   = note_idx + 2'd1;
                end else begin
                    cnt_n = cnt - cnt_t'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // A strictly higher-priority sound abandons the current one outright.
        if (preempt) begin
            state_n = LOAD;
            snd_n   = cand;
            idx_n   = 2'd0;
            pend_n  = cand_vec & ~(4'b0001 << cand);
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            snd_q    <= UI_PRESS;
            note_idx <= 2'd0;
            cnt      <= '0;
            hp_q     <= 16'd0;
            pending  <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            snd_q    <= snd_n;
            note_idx <= idx_n;
            cnt      <= cnt_n;
            hp_q     <= hp_n;
            pending  <= pend_n;
            done_q   <= done_n;
        end
    end

    assign cur_sound        = busy ? snd_q : UI_PRESS;
    assign tone_half_period = (state == PLAY) ? hp_q : 16'd0;
    assign done             = done_q;
`ifdef SOUND_SCHED_MUTE_EN
    assign tone_en = (state == PLAY) && !mute;
`else
    assign tone_en = (state == PLAY);
`endif

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - scoreboard bench for sound_scheduler with NOTE_TICKS=4, GAP_TICKS=2
module tb_sound_scheduler;
    import frogger_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] tone_half_period;
    logic        tone_en, busy, done;
    logic [1:0]  cur_sound;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0;
    bit quiet_bad;

    typedef struct {
        int kind;
        int snd;
        int hp;
        int start;
        int len;
    } ev_t;
    ev_t exp_q[$];

    bit mon_prev = 1'b0;
    int mon_start = 0, mon_hp = 0, mon_snd = 0, mon_last = 0;
    bit mon_end, mon_begin;

    sound_scheduler #(.NOTE_TICKS(4), .GAP_TICKS(2)) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef SOUND_SCHED_MUTE_EN
        .mute             (1'b0),
`endif
        .req              (req),
        .tone_half_period (tone_half_period),
        .tone_en          (tone_en),
        .busy             (busy),
        .cur_sound        (cur_sound),
        .done             (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(input int kind, input int snd, input int hp, input int start, input int len);
        ev_t e;
        e.kind = kind; e.snd = snd; e.hp = hp; e.start = start; e.len = len;
        exp_q.push_back(e);
    endtask

    // kind 0 = finished tone run, kind 1 = done pulse
    task automatic emit(input int kind, input int snd, input int hp, input int start, input int len);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d snd=%0d hp=%0d start=%0d len=%0d, expected no event",
                     kind, snd, hp, start, len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.snd != snd || e.hp != hp || e.start != start || e.len != len) begin
                n_bad++;
                $display("FAIL event: got kind=%0d snd=%0d hp=%0d start=%0d len=%0d, expected kind=%0d snd=%0d hp=%0d start=%0d len=%0d",
                         kind, snd, hp, start, len, e.kind, e.snd, e.hp, e.start, e.len);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_end   = mon_prev && (!tone_en || int'(tone_half_period) != mon_hp || int'(cur_sound) != mon_snd);
            mon_begin = tone_en && (!mon_prev || mon_end);
            if (mon_end) begin
                emit(0, mon_snd, mon_hp, mon_start, cyc - mon_start);
                mon_last = mon_snd;
            end
            if (mon_begin) begin
                mon_start = cyc;
                mon_hp    = int'(tone_half_period);
                mon_snd   = int'(cur_sound);
            end
            if (done)
                emit(1, mon_last, 0, cyc, 0);
            mon_prev = tone_en;
        end
    end

    task automatic pulse_at(input int t, input logic [3:0] v);
        while (cyc < t) @(negedge clk);
        req = v;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_sound"}, cur_sound, 0);
    endtask

    task automatic push_crash_celeb(input int t);
        exp_ev(0, 2, 3000, t + 2, 16);
        exp_ev(0, 2, 4000, t + 21, 32);
        exp_ev(1, 2, 0, t + 53, 0);
        exp_ev(0, 3, 500, t + 55, 8);
        exp_ev(0, 3, 400, t + 66, 8);
        exp_ev(0, 3, 300, t + 77, 8);
        exp_ev(0, 3, 250, t + 88, 32);
        exp_ev(1, 3, 0, t + 120, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_tone_en", tone_en, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_sound", cur_sound, 0);
        check("rst_done", done, 0);
        check("rst_half_period", tone_half_period, 0);
        reset = 1'b0;
        @(negedge clk);

        // single UI_PRESS note
        t0 = cyc;
        exp_ev(0, 0, 1000, t0 + 2, 4);
        exp_ev(1, 0, 0, t0 + 6, 0);
        pulse_at(t0, 4'b0001);
        check("ui_load_busy", busy, 1);
        check("ui_load_tone_en", tone_en, 0);
        wait_drain(40, "ui");

        // NEXTLEVEL three-note sequence, done 40 cycles after request
        t0 = cyc;
        exp_ev(0, 1, 800, t0 + 2, 8);
        exp_ev(0, 1, 600, t0 + 13, 8);
        exp_ev(0, 1, 400, t0 + 24, 16);
        exp_ev(1, 1, 0, t0 + 40, 0);
        pulse_at(t0, 4'b0010);
        check("nl_load_sound", cur_sound, 1);
        wait_drain(80, "nl");

        // CRASH preempts NEXTLEVEL mid-note, no done for NEXTLEVEL
        t0 = cyc;
        exp_ev(0, 1, 800, t0 + 2, 4);
        exp_ev(0, 2, 3000, t0 + 7, 16);
        exp_ev(0, 2, 4000, t0 + 26, 32);
        exp_ev(1, 2, 0, t0 + 58, 0);
        pulse_at(t0, 4'b0010);
        pulse_at(t0 + 5, 4'b0100);
        check("preempt_sound", cur_sound, 2);
        check("preempt_tone_en", tone_en, 0);
        wait_drain(100, "preempt");

        // lower requests latch during CRASH; repeat CRASH request is dropped
        t0 = cyc;
        push_crash_celeb(t0);
        exp_ev(0, 0, 1000, t0 + 122, 4);
        exp_ev(1, 0, 0, t0 + 126, 0);
        pulse_at(t0, 4'b0100);
        pulse_at(t0 + 4, 4'b0001);
        pulse_at(t0 + 6, 4'b1000);
        pulse_at(t0 + 8, 4'b0100);
        wait_drain(200, "latch");

        // all four at once play in priority order
        t0 = cyc;
        push_crash_celeb(t0);
        exp_ev(0, 1, 800, t0 + 122, 8);
        exp_ev(0, 1, 600, t0 + 133, 8);
        exp_ev(0, 1, 400, t0 + 144, 16);
        exp_ev(1, 1, 0, t0 + 160, 0);
        exp_ev(0, 0, 1000, t0 + 162, 4);
        exp_ev(1, 0, 0, t0 + 166, 0);
        pulse_at(t0, 4'b1111);
        wait_drain(240, "all4");

        // reset during PLAY with UI_PRESS pending
        t0 = cyc;
        exp_ev(0, 1, 800, t0 + 2, 4);
        pulse_at(t0, 4'b0010);
        pulse_at(t0 + 3, 4'b0001);
        while (cyc < t0 + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstplay_tone_en", tone_en, 0);
        check("rstplay_busy", busy, 0);
        check("rstplay_cur_sound", cur_sound, 0);
        check("rstplay_done", done, 0);
        reset = 1'b0;
        quiet_bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy || tone_en) quiet_bad = 1'b1;
        end
        check("rstplay_stays_quiet", quiet_bad, 0);
        wait_drain(5, "rstplay");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
